interboard_send: RTL and testbench

Transmit side of the inter-board link. It accepts one game-control message per `ctrl_en` pulse and packs it into four 6-bit frames. It then sends the frames to the other board with a four-phase request/ack handshake. It drives the outgoing halves of the `request` and `interboard_data` pins and monitors the incoming `ack` pin. It sits between the game-control outputs and the pin-level tristate logic inside the inter-board communication top.

---
 rtl/interboard_send.sv | 131 +++++++++++++
 tb/tb_interboard_send.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/interboard_send.sv
// interboard_send: packs a control message into four 6-bit frames sent over a 4-phase request/ack link (in: ctrl_* message, raw ack_in; out: request_out, data_out, data_oe, busy, sticky overflow/timeout)
module interboard_send #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctrl_en,
  input  logic [3:0] ctrl_msg_type,
  input  logic [4:0] ctrl_block_x,
  input  logic [2:0] ctrl_block_y,
  input  logic [5:0] ctrl_card,
  input  logic [2:0] ctrl_sel_len,
  input  logic       ctrl_move_dir,
  input  logic       ack_in,
  output logic       request_out,
  output logic [5:0] data_out,
  output logic       data_oe,
  output logic       busy,
  output logic       overflow,
  output logic       timeout
);
  typedef enum logic [2:0] {IDLE, LOAD, REQ, RELEASE, DONE} state_t;
  state_t      r_state;
  logic [1:0]  r_sync;
  logic [1:0]  r_k;
  logic [23:0] r_act;
  logic [23:0] r_pend;
  logic        r_pend_v;
  logic [31:0] r_cnt;
  logic        r_req;
  logic        r_oe;
  logic [5:0]  r_data;
  logic        r_busy;
  logic        r_ovf;
  logic        r_to;
  logic        w_ack_s;
  logic        w_to_hit;
  logic        w_drive;
  logic [23:0] w_msg;
  logic [5:0]  w_frame;
  assign w_ack_s  = r_sync[1];
  assign w_to_hit = r_cnt == 32'(TIMEOUT_CYCLES - 1);
  assign w_drive  = r_state inside {LOAD, REQ, RELEASE};
  assign w_msg    = {ctrl_msg_type, ctrl_block_x, ctrl_block_y, ctrl_card, ctrl_sel_len, ctrl_move_dir, 2'b00};
  always_comb
    w_frame = r_k == 2'd0 ? r_act[23:18] :
              r_k == 2'd1 ? r_act[17:12] :
              r_k == 2'd2 ? r_act[11:6]  : r_act[5:0];
  assign request_out = r_req;
  assign data_out    = r_data;
  assign data_oe     = r_oe;
  assign busy        = r_busy;
  assign overflow    = r_ovf;
  assign timeout     = r_to;
  // Pin outputs are a registered decode of the state, so they trail it by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_sync   <= '0;
      r_k      <= '0;
      r_act    <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
      r_cnt    <= '0;
      r_req    <= 1'b0;
      r_oe     <= 1'b0;
      r_data   <= '0;
      r_busy   <= 1'b0;
      r_ovf    <= 1'b0;
      r_to     <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], ack_in};
      r_req  <= r_state == REQ;
      r_oe   <= w_drive;
      r_data <= w_drive ? w_frame : '0;
      r_busy <= r_state != IDLE || r_pend_v;
      r_cnt  <= r_cnt + 32'd1;
      // In DONE the pending slot is vacated this same edge, so a new message can take it
      if (ctrl_en && r_state != IDLE) begin
        if (!r_pend_v || r_state == DONE) begin
          r_pend   <= w_msg;
          r_pend_v <= 1'b1;
        end else
          r_ovf <= 1'b1;
      end
      case (r_state)
        IDLE:
          if (r_pend_v) begin
            r_act   <= r_pend;
            r_k     <= '0;
            r_state <= LOAD;
            if (ctrl_en) r_pend <= w_msg;
            else r_pend_v <= 1'b0;
          end else if (ctrl_en) begin
            r_act   <= w_msg;
            r_k     <= '0;
            r_state <= LOAD;
          end
        LOAD: begin
          r_state <= REQ;
          r_cnt   <= '0;
        end
        REQ:
          if (w_ack_s) begin
            r_state <= RELEASE;
            r_cnt   <= '0;
          end else if (w_to_hit) begin
            r_to    <= 1'b1;
            r_state <= IDLE;
          end
        RELEASE:
          if (!w_ack_s) begin
            r_state <= r_k == 2'd3 ? DONE : LOAD;
            r_k     <= r_k + 2'd1;
          end else if (w_to_hit) begin
            r_to    <= 1'b1;
            r_state <= IDLE;
          end
        DONE:
          if (r_pend_v) begin
            r_act   <= r_pend;
            r_k     <= '0;
            r_state <= LOAD;
            if (!ctrl_en) r_pend_v <= 1'b0;
          end else
            r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_interboard_send.sv
// tb_interboard_send: scoreboard bench for interboard_send with an echoing peer model
module tb_interboard_send;
  logic       clk = 0;
  logic       rst = 1;
  logic       ctrl_en = 0;
  logic [3:0] ctrl_msg_type = 0;
  logic [4:0] ctrl_block_x = 0;
  logic [2:0] ctrl_block_y = 0;
  logic [5:0] ctrl_card = 0;
  logic [2:0] ctrl_sel_len = 0;
  logic       ctrl_move_dir = 0;
  logic       ack_in = 0;
  logic       request_out;
  logic [5:0] data_out;
  logic       data_oe;
  logic       busy;
  logic       overflow;
  logic       timeout;
  int checks = 0;
  int errors = 0;
  int rises = 0;
  logic peer_en = 1;
  logic [5:0] exp_q[$];
  interboard_send #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .ctrl_en(ctrl_en), .ctrl_msg_type(ctrl_msg_type),
    .ctrl_block_x(ctrl_block_x), .ctrl_block_y(ctrl_block_y), .ctrl_card(ctrl_card),
    .ctrl_sel_len(ctrl_sel_len), .ctrl_move_dir(ctrl_move_dir), .ack_in(ack_in),
    .request_out(request_out), .data_out(data_out), .data_oe(data_oe),
    .busy(busy), .overflow(overflow), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [5:0] frame(input logic [23:0] w, input int k);
    return w[23-6*k -: 6];
  endfunction
  task automatic send(input logic [3:0] t, input logic [4:0] x, input logic [2:0] y,
                      input logic [5:0] c, input logic [2:0] s, input logic m, input bit push);
    ctrl_msg_type = t; ctrl_block_x = x; ctrl_block_y = y;
    ctrl_card = c; ctrl_sel_len = s; ctrl_move_dir = m;
    ctrl_en = 1;
    if (push) for (int k = 0; k < 4; k++) exp_q.push_back(frame({t, x, y, c, s, m, 2'b00}, k));
    tick;
    ctrl_en = 0;
  endtask
  task automatic wait_idle(input string n);
    int i;
    for (i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !busy && !request_out) break;
      tick;
    end
    if (i == 400) begin
      errors++;
      checks++;
      $display("FAIL %s: idle not reached, %0d frames outstanding", n, exp_q.size());
    end
  endtask
  task automatic chk_reset_vals(input string n);
    chk({n, "_req"}, int'(request_out), 0);
    chk({n, "_data"}, int'(data_out), 0);
    chk({n, "_oe"}, int'(data_oe), 0);
    chk({n, "_busy"}, int'(busy), 0);
    chk({n, "_ovf"}, int'(overflow), 0);
    chk({n, "_to"}, int'(timeout), 0);
  endtask
  initial begin
    logic [2:0] d = 0;
    forever begin
      tick;
      d = {d[1:0], request_out};
      ack_in = peer_en & d[2];
    end
  end
  initial begin
    logic pr = 0;
    logic stable = 1;
    logic [5:0] held = 0;
    forever begin
      @(posedge clk);
      #2;
      if (request_out && !pr) begin
        rises++;
        if (exp_q.size() == 0) chk("frame_unexpected", int'(data_out), -1);
        else chk("frame", int'(data_out), int'(exp_q.pop_front()));
        held = data_out;
        stable = 1;
      end else if (request_out && data_out != held) stable = 0;
      if (!request_out && pr) chk("frame_stable", int'(stable), 1);
      pr = request_out;
    end
  end
  initial begin
    int n, gaps, idles, r0;
    repeat (3) tick;
    chk_reset_vals("reset");
    rst = 0;
    tick;
    exp_q.push_back(6'h0E); exp_q.push_back(6'h0D);
    exp_q.push_back(6'h2A); exp_q.push_back(6'h14);
    send(3, 17, 5, 42, 2, 1, 0);
    tick;
    chk("start_oe", int'(data_oe), 1);
    chk("start_data", int'(data_out), 'h0E);
    chk("start_busy", int'(busy), 1);
    chk("start_req_low", int'(request_out), 0);
    tick;
    chk("start_req", int'(request_out), 1);
    wait_idle("single");
    chk("single_ovf", int'(overflow), 0);
    chk("single_to", int'(timeout), 0);
    chk("single_busy", int'(busy), 0);
    send(9, 3, 2, 7, 5, 0, 1);
    repeat (4) tick;
    send(4'hC, 30, 6, 63, 7, 1, 1);
    gaps = 0;
    idles = 0;
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) begin
      if (!data_oe) gaps++;
      if (!busy) idles++;
      tick;
    end
    chk("b2b_oe_gap", gaps, 1);
    chk("b2b_idle", idles, 0);
    wait_idle("b2b");
    send(1, 1, 1, 1, 1, 1, 1);
    send(2, 4, 3, 21, 6, 0, 1);
    chk("ovf_before", int'(overflow), 0);
    send(5, 9, 7, 50, 3, 1, 0);
    chk("ovf_set", int'(overflow), 1);
    wait_idle("ovf");
    chk("ovf_sticky", int'(overflow), 1);
    peer_en = 0;
    exp_q.push_back(frame({4'd6, 5'd10, 3'd4, 6'd33, 3'd1, 1'b0, 2'b00}, 0));
    send(6, 10, 4, 33, 1, 0, 0);
    for (int i = 0; i < 30 && !request_out; i++) tick;
    n = 0;
    while (request_out && n < 100) begin
      n++;
      tick;
    end
    chk("to_req_len", n, 16);
    chk("to_oe_drop", int'(data_oe), 0);
    chk("to_flag", int'(timeout), 1);
    tick;
    chk("to_idle", int'(busy), 0);
    peer_en = 1;
    repeat (5) tick;
    send(7, 22, 1, 12, 4, 1, 1);
    wait_idle("to_after");
    r0 = rises;
    send(8, 5, 3, 44, 2, 0, 1);
    for (int i = 0; i < 200 && rises != r0 + 3; i++) tick;
    chk("rst_reach_f2", rises, r0 + 3);
    rst = 1;
    tick;
    chk_reset_vals("midrst");
    rst = 0;
    exp_q.delete();
    r0 = rises;
    repeat (20) tick;
    chk("rst_no_req", rises, r0);
    chk("rst_busy", int'(busy), 0);
    send(0, 31, 0, 0, 0, 1, 1);
    wait_idle("rst_after");
    chk("final_to", int'(timeout), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
